// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline sequencer: load-use bubbles, branch/jump flushes, memory freeze, perf counters
module hazard_ctrl #(
  parameter int LU_CYCLES = 1,
  parameter int WAIT_MAX  = 64,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic [4:0]       Wreg_addr_ex,
  input  logic             MemRead_ex,
  input  logic             RegWrite_ex,
  input  logic             branch_taken_ex,
  input  logic             jump_id,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(WAIT_MAX);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  state_t           eff;
  logic [1:0]       lu_cnt_q, lu_cnt_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_inc, flush_inc;
  logic             load_use;

  assign load_use = MemRead_ex & RegWrite_ex & (Wreg_addr_ex != 5'd0) &
                    ((use_rs_id & (rs_id == Wreg_addr_ex)) |
                     (use_rt_id & (rt_id == Wreg_addr_ex)));

  // Next-state and pipeline controls; mem_busy > branch > load-use > jump
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    lu_cnt_d   = lu_cnt_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    // once memory is ready again, a wait episode behaves exactly like the state it interrupted
    eff        = (state_q == MEM_WAIT) ? ret_q : state_q;

    if (mem_busy) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      stall_inc = 1'b1;
      if (state_q == MEM_WAIT) begin
        if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + WW'(1);
      end else begin
        ret_d      = state_q;
        state_d    = MEM_WAIT;
        wait_cnt_d = WW'(1);
      end
      if (wait_cnt_d >= WAIT_LIM) timeout_d = 1'b1;
    end else begin
      wait_cnt_d = '0;
      state_d    = eff;
      if (eff == LU_STALL) begin
        // EX already holds the load or a bubble, so branch/load-use are not evaluated here
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
        lu_cnt_d   = lu_cnt_q - 2'd1;
        if (lu_cnt_q == 2'd1) state_d = RUN;
      end else if (branch_taken_ex) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
        if (LU_CYCLES > 1) begin
          lu_cnt_d = 2'(LU_CYCLES - 1);
          state_d  = LU_STALL;
        end
      end else if (jump_id) begin
        ifid_flush = 1'b1;
        flush_inc  = 1'b1;
      end
    end

    // reset holds the pipe frozen and loading NOPs
    if (!RSTn) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end

    stall_cnt_d = (stall_inc && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush_inc && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  // State registers update on the falling edge alongside the pipeline registers
  always_ff @(negedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= RUN;
      ret_q       <= RUN;
      lu_cnt_q    <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      lu_cnt_q    <= lu_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic [4:0] rs_id, rt_id, Wreg_addr_ex;
  logic       use_rs_id, use_rt_id, MemRead_ex, RegWrite_ex;
  logic       branch_taken_ex, jump_id, mem_busy;

  logic        pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_flush1, exmem_en1, timeout1;
  logic [15:0] stall1, flush1;
  logic        pc_en2, ifid_en2, ifid_flush2, idex_en2, idex_flush2, exmem_en2, timeout2;
  logic [2:0]  stall2, flush2;
  logic [5:0]  ctl1, ctl2;

  int tests = 0;
  int fails = 0;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
  localparam logic [5:0] NORM = 6'b110101;
  localparam logic [5:0] RSTV = 6'b001010;
  localparam logic [5:0] LUB  = 6'b000111;
  localparam logic [5:0] BR   = 6'b111111;
  localparam logic [5:0] JMP  = 6'b111101;
  localparam logic [5:0] FRZ  = 6'b000000;

  always #5 CLK = ~CLK;

  assign ctl1 = {pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_flush1, exmem_en1};
  assign ctl2 = {pc_en2, ifid_en2, ifid_flush2, idex_en2, idex_flush2, exmem_en2};

  hazard_ctrl #(.LU_CYCLES(1), .WAIT_MAX(4), .CNT_W(16)) dut1 (
    .CLK(CLK), .RSTn(RSTn), .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id),
    .use_rt_id(use_rt_id), .Wreg_addr_ex(Wreg_addr_ex), .MemRead_ex(MemRead_ex),
    .RegWrite_ex(RegWrite_ex), .branch_taken_ex(branch_taken_ex), .jump_id(jump_id),
    .mem_busy(mem_busy), .pc_en(pc_en1), .ifid_en(ifid_en1), .ifid_flush(ifid_flush1),
    .idex_en(idex_en1), .idex_flush(idex_flush1), .exmem_en(exmem_en1),
    .mem_timeout(timeout1), .stall_cnt(stall1), .flush_cnt(flush1));

  hazard_ctrl #(.LU_CYCLES(2), .WAIT_MAX(64), .CNT_W(3)) dut2 (
    .CLK(CLK), .RSTn(RSTn), .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id),
    .use_rt_id(use_rt_id), .Wreg_addr_ex(Wreg_addr_ex), .MemRead_ex(MemRead_ex),
    .RegWrite_ex(RegWrite_ex), .branch_taken_ex(branch_taken_ex), .jump_id(jump_id),
    .mem_busy(mem_busy), .pc_en(pc_en2), .ifid_en(ifid_en2), .ifid_flush(ifid_flush2),
    .idex_en(idex_en2), .idex_flush(idex_flush2), .exmem_en(exmem_en2),
    .mem_timeout(timeout2), .stall_cnt(stall2), .flush_cnt(flush2));

  task automatic idle();
    rs_id = 5'd0; rt_id = 5'd0; Wreg_addr_ex = 5'd0;
    use_rs_id = 1'b0; use_rt_id = 1'b0; MemRead_ex = 1'b0; RegWrite_ex = 1'b0;
    branch_taken_ex = 1'b0; jump_id = 1'b0; mem_busy = 1'b0;
  endtask

  // lw $2 in EX, ID instruction reads rs=$2
  task automatic hazard();
    idle();
    MemRead_ex = 1'b1; RegWrite_ex = 1'b1; Wreg_addr_ex = 5'd2;
    rs_id = 5'd2; use_rs_id = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge CLK); idle(); RSTn = 1'b0;
    @(posedge CLK); RSTn = 1'b1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0; idle(); mem_busy = 1'b1; branch_taken_ex = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    tests++; if (ctl1 !== RSTV) begin fails++; $display("FAIL reset_ctl1 got=%b exp=%b", ctl1, RSTV); end
    tests++; if (ctl2 !== RSTV) begin fails++; $display("FAIL reset_ctl2 got=%b exp=%b", ctl2, RSTV); end
    tests++; if ({stall1, flush1, timeout1} !== 33'd0) begin fails++;
      $display("FAIL reset_state stall=%0d flush=%0d to=%b exp=0", stall1, flush1, timeout1); end
    @(posedge CLK); idle(); RSTn = 1'b1; #1;
    tests++; if (ctl1 !== NORM) begin fails++; $display("FAIL idle_ctl1 got=%b exp=%b", ctl1, NORM); end
  endtask

  task automatic test_load_use();
    do_reset();
    hazard(); #1;
    tests++; if (ctl1 !== LUB) begin fails++; $display("FAIL lu1_bubble got=%b exp=%b", ctl1, LUB); end
    tests++; if (ctl2 !== LUB) begin fails++; $display("FAIL lu2_bubble0 got=%b exp=%b", ctl2, LUB); end
    @(posedge CLK); idle(); #1;
    tests++; if (ctl1 !== NORM) begin fails++; $display("FAIL lu1_resume got=%b exp=%b", ctl1, NORM); end
    tests++; if (ctl2 !== LUB) begin fails++; $display("FAIL lu2_bubble1 got=%b exp=%b", ctl2, LUB); end
    tests++; if (stall1 !== 16'd1) begin fails++; $display("FAIL lu1_stall_cnt got=%0d exp=1", stall1); end
    @(posedge CLK); idle(); #1;
    tests++; if (ctl2 !== NORM) begin fails++; $display("FAIL lu2_resume got=%b exp=%b", ctl2, NORM); end
    tests++; if (stall2 !== 3'd2) begin fails++; $display("FAIL lu2_stall_cnt got=%0d exp=2", stall2); end
  endtask

  task automatic test_no_hazard();
    do_reset();
    hazard(); Wreg_addr_ex = 5'd0; rs_id = 5'd0; #1;
    tests++; if (ctl1 !== NORM) begin fails++; $display("FAIL nohz_r0 got=%b exp=%b", ctl1, NORM); end
    @(posedge CLK); hazard(); use_rs_id = 1'b0; rt_id = 5'd3; use_rt_id = 1'b1; #1;
    tests++; if (ctl1 !== NORM) begin fails++; $display("FAIL nohz_unused got=%b exp=%b", ctl1, NORM); end
    @(posedge CLK); idle(); #1;
    tests++; if (stall1 !== 16'd0 || stall2 !== 3'd0) begin fails++;
      $display("FAIL nohz_stall_cnt got=%0d/%0d exp=0/0", stall1, stall2); end
    @(posedge CLK); hazard(); use_rs_id = 1'b0; rt_id = 5'd2; use_rt_id = 1'b1; #1;
    tests++; if (ctl1 !== LUB) begin fails++; $display("FAIL hz_rt got=%b exp=%b", ctl1, LUB); end
  endtask

  task automatic test_branch_priority();
    do_reset();
    hazard(); branch_taken_ex = 1'b1; #1;
    tests++; if (ctl1 !== BR) begin fails++; $display("FAIL br_lu_ctl1 got=%b exp=%b", ctl1, BR); end
    tests++; if (ctl2 !== BR) begin fails++; $display("FAIL br_lu_ctl2 got=%b exp=%b", ctl2, BR); end
    @(posedge CLK); idle(); #1;
    tests++; if (flush1 !== 16'd1 || stall1 !== 16'd0) begin fails++;
      $display("FAIL br_cnts flush=%0d stall=%0d exp=1/0", flush1, stall1); end
    tests++; if (ctl2 !== NORM) begin fails++; $display("FAIL br_no_lustall got=%b exp=%b", ctl2, NORM); end
  endtask

  task automatic test_jump();
    do_reset();
    idle(); jump_id = 1'b1; #1;
    tests++; if (ctl1 !== JMP) begin fails++; $display("FAIL jump_ctl got=%b exp=%b", ctl1, JMP); end
    @(posedge CLK); hazard(); jump_id = 1'b1; #1;
    tests++; if (ctl1 !== LUB) begin fails++; $display("FAIL jump_vs_lu got=%b exp=%b", ctl1, LUB); end
    @(posedge CLK); idle(); #1;
    tests++; if (flush1 !== 16'd1 || stall1 !== 16'd1) begin fails++;
      $display("FAIL jump_cnts flush=%0d stall=%0d exp=1/1", flush1, stall1); end
  endtask

  task automatic test_mem_in_lu_stall();
    do_reset();
    hazard(); #1;
    tests++; if (ctl2 !== LUB) begin fails++; $display("FAIL mlu_first got=%b exp=%b", ctl2, LUB); end
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); idle(); mem_busy = 1'b1; #1;
      tests++; if (ctl2 !== FRZ || ctl1 !== FRZ) begin fails++;
        $display("FAIL mlu_freeze%0d got=%b/%b exp=%b", i, ctl2, ctl1, FRZ); end
    end
    @(posedge CLK); idle(); #1;
    tests++; if (ctl2 !== LUB) begin fails++; $display("FAIL mlu_resume_bubble got=%b exp=%b", ctl2, LUB); end
    tests++; if (ctl1 !== NORM) begin fails++; $display("FAIL mlu_dut1_run got=%b exp=%b", ctl1, NORM); end
    @(posedge CLK); idle(); #1;
    tests++; if (ctl2 !== NORM) begin fails++; $display("FAIL mlu_done got=%b exp=%b", ctl2, NORM); end
    tests++; if (stall2 !== 3'd5) begin fails++; $display("FAIL mlu_stall_cnt got=%0d exp=5", stall2); end
    tests++; if (stall1 !== 16'd4 || timeout1 !== 1'b0) begin fails++;
      $display("FAIL mlu_dut1 stall=%0d to=%b exp=4/0", stall1, timeout1); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) @(posedge CLK);
      idle(); mem_busy = 1'b1; #1;
      tests++; if (ctl1 !== FRZ) begin fails++; $display("FAIL to_freeze%0d got=%b exp=%b", i, ctl1, FRZ); end
      tests++; if (timeout1 !== (i >= 5)) begin fails++;
        $display("FAIL to_flag%0d got=%b exp=%b", i, timeout1, (i >= 5)); end
    end
    @(posedge CLK); idle(); #1;
    tests++; if (timeout1 !== 1'b1 || ctl1 !== NORM) begin fails++;
      $display("FAIL to_sticky to=%b ctl=%b exp=1/%b", timeout1, ctl1, NORM); end
    tests++; if (stall1 !== 16'd8) begin fails++; $display("FAIL to_stall_cnt got=%0d exp=8", stall1); end
    tests++; if (stall2 !== 3'd7 || timeout2 !== 1'b0) begin fails++;
      $display("FAIL sat_stall2 stall=%0d to=%b exp=7/0", stall2, timeout2); end
    @(posedge CLK); #1;
    tests++; if (timeout1 !== 1'b1) begin fails++; $display("FAIL to_sticky2 got=%b exp=1", timeout1); end
    do_reset(); #1;
    tests++; if ({stall1, flush1, timeout1} !== 33'd0) begin fails++;
      $display("FAIL to_cleared stall=%0d flush=%0d to=%b exp=0", stall1, flush1, timeout1); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    hazard(); #1;
    tests++; if (ctl2 !== LUB) begin fails++; $display("FAIL rms_bubble got=%b exp=%b", ctl2, LUB); end
    @(posedge CLK); idle(); RSTn = 1'b0; #1;
    tests++; if (ctl2 !== RSTV) begin fails++; $display("FAIL rms_reset got=%b exp=%b", ctl2, RSTV); end
    @(posedge CLK); RSTn = 1'b1; #1;
    tests++; if (ctl2 !== NORM || stall2 !== 3'd0) begin fails++;
      $display("FAIL rms_no_pending ctl=%b stall=%0d exp=%b/0", ctl2, stall2, NORM); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_priority();
    test_jump();
    test_mem_in_lu_stall();
    test_timeout();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
